// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational 16-bit ALU between two requesters
//            (port 0 = execute stage, port 1 = address-gen/aux unit).
//            Round-robin grant, one op per cycle, result captured in a
//            one-entry response register with valid/ready backpressure.
//            Owns the architectural Z/V flags; only legal port-0 ops
//            update them.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            req{0,1}_valid/ready      - request handshake per port
//            req{0,1}_op/a/b           - opcode and operands per port
//            alu_r1/alu_r2/alu_code    - drive to the shared ALU
//            alu_result/ovfl/zero      - ALU outputs (same cycle)
//            rsp_valid/ready           - response handshake
//            rsp_id/data/err           - held response
//            flag_z/flag_v             - architectural flags
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [OP_W-1:0]   alu_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              flag_z,
    output logic              flag_v
);

    localparam logic [OP_W-1:0] c_op_nop         = '0;
    localparam logic [OP_W-1:0] c_op_illegal_min = OP_W'(12);
    localparam logic [OP_W-1:0] c_op_z_max       = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_v_max       = OP_W'(1);

    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_flag_z;
    logic              r_flag_v;
    logic              r_rr_ptr;

    logic              w_can_issue;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic [OP_W-1:0]   w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_illegal;

    // Slot can accept when empty, or when the held result leaves this cycle.
    // Gating with rst keeps any request in the reset cycle from being taken.
    assign w_can_issue = !rst && (!r_rsp_valid || rsp_ready);

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (w_can_issue) begin
            if (req0_valid && req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = r_rr_ptr;
            end else if (req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    assign w_op      = w_grant_id ? req1_op : req0_op;
    assign w_a       = w_grant_id ? req1_a  : req0_a;
    assign w_b       = w_grant_id ? req1_b  : req0_b;
    assign w_illegal = (w_op >= c_op_illegal_min);

    assign req0_ready = w_grant_valid && !w_grant_id;
    assign req1_ready = w_grant_valid &&  w_grant_id;

    // Idle or illegal ops present a quiet NOP to the ALU.
    assign alu_r1   = w_grant_valid ? w_a : '0;
    assign alu_r2   = w_grant_valid ? w_b : '0;
    assign alu_code = (w_grant_valid && !w_illegal) ? w_op : c_op_nop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_rr_ptr    <= 1'b0;
        end else if (w_grant_valid) begin
            // Covers both the empty fill and the back-to-back refill.
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_grant_id;
            r_rsp_data  <= w_illegal ? '0 : alu_result;
            r_rsp_err   <= w_illegal;
            r_rr_ptr    <= ~w_grant_id;
            if (!w_grant_id && !w_illegal) begin
                if (w_op <= c_op_z_max) begin
                    r_flag_z <= alu_zero;
                end
                if (w_op <= c_op_v_max) begin
                    r_flag_v <= alu_ovfl;
                end
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign flag_z    = r_flag_z;
    assign flag_v    = r_flag_v;

endmodule
`default_nettype wire
